// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet field positions, directions, NIC register map.
package noc_pkg;

  localparam int VC_BIT          = 63;
  localparam int NORTH_SOUTH_BIT = 62;
  localparam int EAST_WEST_BIT   = 61;

  localparam int Y_HOP_MSB = 55;
  localparam int X_HOP_MSB = 51;
  localparam int Y_SRC_MSB = 47;
  localparam int X_SRC_MSB = 39;
  localparam int SRC_W     = 8;

  localparam logic NORTH_TO_SOUTH = 1'b0;
  localparam logic SOUTH_TO_NORTH = 1'b1;
  localparam logic EAST_TO_WEST   = 1'b0;
  localparam logic WEST_TO_EAST   = 1'b1;

  localparam logic [1:0] NIC_ADDR_IN_BUF   = 2'd0;
  localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'd1;
  localparam logic [1:0] NIC_ADDR_OUT_BUF  = 2'd2;
  localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'd3;

  // Replace the source Y/X fields with the attached router's coordinates.
  function automatic logic [63:0] stamp_src(
    input logic [63:0] pkt,
    input logic [3:0]  pos
  );
    logic [63:0] r;
    r = pkt;
    r[Y_SRC_MSB -: SRC_W] = {6'b0, pos[3:2]};
    r[X_SRC_MSB -: SRC_W] = {6'b0, pos[1:0]};
    return r;
  endfunction

endpackage

// File: rtl/nic_buffer.sv
// Single-entry packet buffer with full flag.
// A load in the same cycle as a clear wins, so no arriving packet is lost.
module nic_buffer
  import noc_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      q    <= d;
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/pe_nic.sv
// PE network interface: host register port <-> router pe channel pair.
// Optional PE_NIC_SRC_STAMP_EN stamps router_position into the source fields.
module pe_nic
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            router_position,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  nic_en,
  input  logic                  nic_wr_en,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  net_polarity,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di
);

  logic                  rd;
  logic                  wr;
  logic                  out_full;
  logic                  in_full;
  logic [DATA_WIDTH-1:0] out_buf;
  logic [DATA_WIDTH-1:0] in_buf;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  out_load;
  logic                  in_load;
  logic                  in_clear;

  assign rd = nic_en & ~nic_wr_en;
  assign wr = nic_en & nic_wr_en;

`ifdef PE_NIC_SRC_STAMP_EN
  assign wr_data = DATA_WIDTH'(stamp_src(d_in, router_position));
`else
  logic unused_pos;
  assign unused_pos = ^router_position;
  assign wr_data    = d_in;
`endif

  // out_full is sampled before the send clears it, so a write racing a send drops
  assign out_load = wr & ~out_full
                  & (addr == ADDR_WIDTH'(NIC_ADDR_OUT_BUF));
  assign in_load  = net_si & net_ri;
  assign in_clear = rd & (addr == ADDR_WIDTH'(NIC_ADDR_IN_BUF));

  assign net_so = out_full & net_ro
                & (net_polarity == out_buf[VC_BIT]);
  assign net_do = out_full ? out_buf : '0;
  assign net_ri = ~in_full;

  nic_buffer #(.WIDTH(DATA_WIDTH)) u_out_buf (
    .clk  (clk),
    .reset(reset),
    .load (out_load),
    .clear(net_so),
    .d    (wr_data),
    .q    (out_buf),
    .full (out_full)
  );

  nic_buffer #(.WIDTH(DATA_WIDTH)) u_in_buf (
    .clk  (clk),
    .reset(reset),
    .load (in_load),
    .clear(in_clear),
    .d    (net_di),
    .q    (in_buf),
    .full (in_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_out <= '0;
    end else if (rd) begin
      unique case (1'b1)
        addr == ADDR_WIDTH'(NIC_ADDR_IN_BUF):
          d_out <= in_buf;
        addr == ADDR_WIDTH'(NIC_ADDR_IN_STAT):
          d_out <= DATA_WIDTH'(in_full);
        addr == ADDR_WIDTH'(NIC_ADDR_OUT_STAT):
          d_out <= DATA_WIDTH'(out_full);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_nic.sv
// Scoreboard bench for pe_nic: directed scenarios, random traffic, async reset.
module tb_pe_nic;

  logic        clk;
  logic        rst_n;
  logic [3:0]  router_position;
  logic [1:0]  addr;
  logic        nic_en;
  logic        nic_wr_en;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        net_polarity;
  logic        net_so;
  logic        net_ro;
  logic [63:0] net_do;
  logic        net_si;
  logic        net_ri;
  logic [63:0] net_di;

  int errors = 0;
  int checks = 0;
  bit mon_on = 0;

  typedef struct {
    logic        so;
    logic        ri;
    logic [63:0] d;
  } comb_t;

  comb_t       comb_q[$];
  logic [63:0] rd_q[$];

  // Reference state: each slot is a queue holding at most one packet.
  logic [63:0] m_out[$];
  logic [63:0] m_in[$];
  logic [63:0] m_last_in;
  logic [63:0] m_dout;

  pe_nic dut (
    .clk            (clk),
    .reset          (rst_n),
    .router_position(router_position),
    .addr           (addr),
    .nic_en         (nic_en),
    .nic_wr_en      (nic_wr_en),
    .d_in           (d_in),
    .d_out          (d_out),
    .net_polarity   (net_polarity),
    .net_so         (net_so),
    .net_ro         (net_ro),
    .net_do         (net_do),
    .net_si         (net_si),
    .net_ri         (net_ri),
    .net_di         (net_di)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] host_pkt(logic [63:0] d, logic [3:0] pos);
    logic [63:0] r;
    r = d;
`ifdef PE_NIC_SRC_STAMP_EN
    r[47:40] = {6'b0, pos[3:2]};
    r[39:32] = {6'b0, pos[1:0]};
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      if (comb_q.size() != 0) begin
        comb_t e;
        e = comb_q.pop_front();
        check("net_so", {63'b0, net_so}, {63'b0, e.so});
        check("net_ri", {63'b0, net_ri}, {63'b0, e.ri});
        check("net_do", net_do, e.d);
      end
      if (rd_q.size() != 0) check("d_out", d_out, rd_q.pop_front());
    end
  end

  task automatic drive(bit en, bit wr, logic [1:0] a, logic [63:0] d,
                       bit ro, bit pol, bit si, logic [63:0] di);
    nic_en = en; nic_wr_en = wr; addr = a; d_in = d;
    net_ro = ro; net_polarity = pol; net_si = si; net_di = di;
  endtask

  task automatic step();
    comb_t e;
    bit    send, rx, rd, had_out;
    logic [63:0] rv;
    e.so = (m_out.size() != 0) && net_ro && (net_polarity == m_out[0][63]);
    e.d  = (m_out.size() != 0) ? m_out[0] : 64'h0;
    e.ri = (m_in.size() == 0);
    comb_q.push_back(e);
    send = e.so;
    rx   = net_si && e.ri;
    rd   = nic_en && !nic_wr_en;
    rv   = m_dout;
    if (rd) begin
      case (addr)
        2'd0: rv = m_last_in;
        2'd1: rv = {63'b0, m_in.size() != 0};
        2'd3: rv = {63'b0, m_out.size() != 0};
        default: rv = m_dout;
      endcase
    end
    @(posedge clk);
    had_out = (m_out.size() != 0);
    if (send) void'(m_out.pop_front());
    if (nic_en && nic_wr_en && addr == 2'd2 && !had_out)
      m_out.push_back(host_pkt(d_in, router_position));
    if (rd && addr == 2'd0) m_in.delete();
    if (rx) begin
      m_in.delete();
      m_in.push_back(net_di);
      m_last_in = net_di;
    end
    if (rd) begin
      m_dout = rv;
      rd_q.push_back(rv);
    end
    #1;
  endtask

  task automatic idle(bit ro, bit pol);
    drive(0, 0, 2'd0, 64'h0, ro, pol, 0, 64'h0);
    step();
  endtask

  initial begin
    rst_n = 0;
    router_position = 4'b0000;
    drive(0, 0, 2'd0, 64'h0, 0, 0, 0, 64'h0);
    m_last_in = 0;
    m_dout = 0;
    #3;
    check("rst d_out", d_out, 64'h0);
    check("rst net_so", {63'b0, net_so}, 64'h0);
    check("rst net_ri", {63'b0, net_ri}, 64'h1);
    check("rst net_do", net_do, 64'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    mon_on = 1;

    // Polarity gating
    drive(1, 1, 2'd2, 64'h8000_0000_0010_0000, 0, 0, 0, 64'h0);
    step();
    idle(1, 0);
    idle(1, 0);
    idle(1, 1);
    drive(1, 0, 2'd3, 64'h0, 1, 0, 0, 64'h0);
    step();
    idle(0, 0);

    // Back-pressure: second write while full is dropped
    drive(1, 1, 2'd2, 64'h0000_0000_0020_0005, 0, 0, 0, 64'h0);
    step();
    idle(0, 0);
    drive(1, 1, 2'd2, 64'h1234, 0, 0, 0, 64'h0);
    step();
    repeat (3) idle(0, 0);
    idle(1, 0);
    idle(1, 0);
    idle(1, 1);

    // Receive then read
    drive(0, 0, 2'd0, 64'h0, 0, 0, 1, 64'h0000_0000_DEAD_BEEF);
    step();
    drive(1, 0, 2'd1, 64'h0, 0, 0, 1, 64'h1111);
    step();
    drive(1, 0, 2'd0, 64'h0, 0, 0, 1, 64'h2222);
    step();
    idle(0, 0);
    drive(1, 0, 2'd0, 64'h0, 0, 0, 0, 64'h0);
    step();

    // Simultaneous transmit and receive
    drive(1, 1, 2'd2, 64'h8000_0000_0001_0077, 0, 0, 0, 64'h0);
    step();
    drive(0, 0, 2'd0, 64'h0, 1, 1, 1, 64'h0000_0000_0000_ABCD);
    step();
    drive(1, 0, 2'd3, 64'h0, 0, 0, 0, 64'h0);
    step();
    drive(1, 0, 2'd1, 64'h0, 0, 0, 0, 64'h0);
    step();
    drive(1, 0, 2'd0, 64'h0, 0, 0, 0, 64'h0);
    step();

    // Source stamp (data unchanged when the feature is off)
    router_position = 4'b1001;
    drive(1, 1, 2'd2, 64'h0000_FFFF_0000_0001, 0, 0, 0, 64'h0);
    step();
`ifdef PE_NIC_SRC_STAMP_EN
    check("stamp net_do", net_do, 64'h0000_0201_0000_0001);
`else
    check("stamp net_do", net_do, 64'h0000_FFFF_0000_0001);
`endif
    idle(1, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      router_position = 4'($urandom);
      drive($urandom_range(0, 1), $urandom_range(0, 1),
            2'($urandom), {$urandom, $urandom},
            $urandom_range(0, 9) < 7, $urandom_range(0, 1),
            $urandom_range(0, 9) < 4, {$urandom, $urandom});
      step();
    end

    // Async reset mid-operation with both buffers full
    drive(1, 1, 2'd2, 64'h8000_0000_0030_0042, 0, 0, 1, 64'h55);
    step();
    drive(1, 0, 2'd0, 64'h0, 0, 0, 0, 64'h0);
    step();
    drive(1, 1, 2'd2, 64'h8000_0000_0030_0042, 0, 0, 1, 64'h66);
    step();
    drive(1, 0, 2'd1, 64'h0, 0, 0, 0, 64'h0);
    step();
    idle(0, 0);
    @(negedge clk);
    mon_on = 0;
    check("pre-rst d_out", d_out, 64'h1);
    check("pre-rst net_ri", {63'b0, net_ri}, 64'h0);
    #2 rst_n = 0;
    #1;
    check("mid-rst net_so", {63'b0, net_so}, 64'h0);
    check("mid-rst net_ri", {63'b0, net_ri}, 64'h1);
    check("mid-rst d_out", d_out, 64'h0);
    check("mid-rst net_do", net_do, 64'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    drive(1, 0, 2'd1, 64'h0, 1, 1, 0, 64'h0);
    @(posedge clk);
    #1;
    check("post-rst in_stat", d_out, 64'h0);
    drive(1, 0, 2'd3, 64'h0, 1, 1, 0, 64'h0);
    @(posedge clk);
    #1;
    check("post-rst out_stat", d_out, 64'h0);
    check("post-rst net_so", {63'b0, net_so}, 64'h0);
    check("post-rst net_ri", {63'b0, net_ri}, 64'h1);
    if (comb_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard drain: %0d/%0d entries left",
               comb_q.size(), rd_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
